// File: rtl/run_monitor.sv
// run_monitor: tracks one program run from start to drain or timeout,
// snapshotting watched writeback registers and counting retirements.
module run_monitor #(
  parameter int DATA_W         = 32,
  parameter int NUM_WB         = 2,
  parameter int NUM_WATCH      = 2,
  parameter int WATCH_BASE     = 10,
  parameter int DRAIN_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [5*NUM_WB-1:0]         wb_addr,
  input  logic [DATA_W*NUM_WB-1:0]    wb_data,
  input  logic                        fetch_complete,
  input  logic                        pipe_busy,
  output logic [NUM_WATCH-1:0]        watch_ready,
  output logic [DATA_W*NUM_WATCH-1:0] watch_value,
  output logic                        busy,
  output logic                        done,
  output logic                        timed_out,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [CNT_W-1:0]            retired_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int IW = $clog2(NUM_WB + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    TIMEOUT
  } state_t;

  state_t state, state_n;

  logic [DW-1:0]            drain_cnt;
  logic                     active;
  logic                     restart;
  logic                     idle_cyc;
  logic                     drain_hit;
  logic                     tmo_hit;
  logic [IW-1:0]            ret_inc;
  logic [CNT_W:0]           ret_sum;
  logic [NUM_WATCH-1:0]     rdy_n;
  logic [DATA_W*NUM_WATCH-1:0] val_n;

  assign active   = (state == RUN) || (state == DRAIN);
  assign restart  = start &&
                    ((state == IDLE) || (state == DONE) ||
                     (state == TIMEOUT));
  assign idle_cyc = !pipe_busy && (wb_valid == '0);
  assign drain_hit = (state == DRAIN) && idle_cyc &&
                     (drain_cnt == DW'(DRAIN_CYCLES - 1));
  assign tmo_hit  = active && !drain_hit &&
                    (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  assign busy      = active;
  assign done      = (state == DONE);
  assign timed_out = (state == TIMEOUT);

  // next-state selection; completion outranks timeout
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN: begin
        if (tmo_hit)             state_n = TIMEOUT;
        else if (fetch_complete) state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_hit)    state_n = DONE;
        else if (tmo_hit) state_n = TIMEOUT;
      end
      DONE:    if (start) state_n = RUN;
      TIMEOUT: if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  // watched-register capture; later ports overwrite earlier ones
  always_comb begin
    rdy_n   = watch_ready;
    val_n   = watch_value;
    ret_inc = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && (wb_addr[5*i +: 5] != 5'd0)) begin
        ret_inc = ret_inc + IW'(1);
        for (int k = 0; k < NUM_WATCH; k++) begin
          if (wb_addr[5*i +: 5] == 5'(WATCH_BASE + k)) begin
            rdy_n[k] = 1'b1;
            val_n[DATA_W*k +: DATA_W] = wb_data[DATA_W*i +: DATA_W];
          end
        end
      end
    end
    ret_sum = {1'b0, retired_count} + (CNT_W+1)'(ret_inc);
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // consecutive idle-cycle counter while draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt <= '0;
    end else if (restart) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      if (!idle_cyc)      drain_cnt <= '0;
      else if (drain_hit) drain_cnt <= '0;
      else                drain_cnt <= drain_cnt + DW'(1);
    end
  end

  // run-length and retirement counters, both saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else if (restart) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else if (active) begin
      if (cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
      if (ret_sum[CNT_W])
        retired_count <= '1;
      else
        retired_count <= ret_sum[CNT_W-1:0];
    end
  end

  // watched-register snapshot registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      watch_ready <= '0;
      watch_value <= '0;
    end else if (restart) begin
      watch_ready <= '0;
      watch_value <= '0;
    end else if (active) begin
      watch_ready <= rdy_n;
      watch_value <= val_n;
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed and randomized checks of run_monitor
// against a cycle-level behavioural model.
module tb_run_monitor;

  localparam int DATA_W  = 32;
  localparam int NUM_WB  = 2;
  localparam int NUM_W   = 2;
  localparam int BASE    = 10;
  localparam int DRAIN   = 8;
  localparam int TMO     = 20;
  localparam int CNT_W   = 16;
  localparam int CMAX    = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
  logic        fetch_complete;
  logic        pipe_busy;
  logic [1:0]  watch_ready;
  logic [63:0] watch_value;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [15:0] cycle_count;
  logic [15:0] retired_count;

  int vectors     = 0;
  int miscompares = 0;

  // model: 0 idle, 1 run, 2 drain, 3 done, 4 timeout
  int          m_ph;
  int          m_drain;
  int          m_cyc;
  int          m_ret;
  bit [1:0]    m_rdy;
  logic [31:0] m_val [2];

  run_monitor #(
    .DATA_W(DATA_W), .NUM_WB(NUM_WB), .NUM_WATCH(NUM_W),
    .WATCH_BASE(BASE), .DRAIN_CYCLES(DRAIN),
    .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .fetch_complete(fetch_complete), .pipe_busy(pipe_busy),
    .watch_ready(watch_ready), .watch_value(watch_value),
    .busy(busy), .done(done), .timed_out(timed_out),
    .cycle_count(cycle_count), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_ph = 0; m_drain = 0; m_cyc = 0; m_ret = 0;
    m_rdy = 2'b00; m_val[0] = '0; m_val[1] = '0;
  endfunction

  function automatic void model_edge();
    int n;
    int a;
    int old;
    bit fin;
    bit idle;
    if (start && (m_ph == 0 || m_ph == 3 || m_ph == 4)) begin
      model_reset();
      m_ph = 1;
      return;
    end
    if (m_ph != 1 && m_ph != 2) return;
    n = 0;
    for (int p = 0; p < NUM_WB; p++) begin
      a = int'(wb_addr[5*p +: 5]);
      if (wb_valid[p] && a != 0) begin
        n++;
        if (a >= BASE && a < BASE + NUM_W) begin
          m_val[a-BASE] = wb_data[32*p +: 32];
          m_rdy[a-BASE] = 1'b1;
        end
      end
    end
    m_ret = (m_ret + n > CMAX) ? CMAX : m_ret + n;
    fin = 1'b0;
    if (m_ph == 2) begin
      idle = !pipe_busy && (wb_valid == 2'b00);
      if (idle) begin
        m_drain++;
        fin = (m_drain == DRAIN);
      end else begin
        m_drain = 0;
      end
    end
    old = m_cyc;
    if (m_cyc < CMAX) m_cyc++;
    if (fin)                           m_ph = 3;
    else if (old == TMO - 1)           m_ph = 4;
    else if (m_ph == 1 && fetch_complete) m_ph = 2;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; wb_valid = '0; wb_addr = '0; wb_data = '0;
    fetch_complete = 0; pipe_busy = 0;
  endtask

  task automatic wb(input int p, input logic [4:0] a,
                    input logic [31:0] d);
    wb_valid[p]       = 1'b1;
    wb_addr[5*p +: 5]  = a;
    wb_data[32*p +: 32] = d;
  endtask

  task automatic go();
    idle_in();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 0;
    #3;
    model_reset();
    vectors++;
    if ({watch_ready, watch_value, cycle_count, retired_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %0h want 0",
               {watch_ready, watch_value, cycle_count, retired_count});
    end
    vectors++;
    if ({busy, done, timed_out} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000",
               {busy, done, timed_out});
    end
    @(posedge clk);
    #1;
    reset = 1;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_start: busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int n;
    go();
    vectors++;
    if (busy !== 1'b1 || cycle_count !== 16'd0) begin
      miscompares++;
      $display("FAIL basic_start: busy %b cyc %0d want 1 0",
               busy, cycle_count);
    end
    wb(0, 5'd10, 32'h0000_0005);
    wb(1, 5'd11, 32'hDEAD_BEEF);
    pipe_busy = 1;
    step();
    vectors++;
    if (watch_ready !== 2'b11 ||
        watch_value !== {32'hDEAD_BEEF, 32'h0000_0005}) begin
      miscompares++;
      $display("FAIL basic_capture: rdy %b val %h want 11 deadbeef00000005",
               watch_ready, watch_value);
    end
    idle_in();
    fetch_complete = 1;
    step();
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (done !== 1'b1 || n !== DRAIN) begin
      miscompares++;
      $display("FAIL basic_done: done %b after %0d idle want 1 after %0d",
               done, n, DRAIN);
    end
    vectors++;
    if (retired_count !== 16'd2 || watch_ready !== 2'b11 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_final: ret %0d rdy %b busy %b want 2 11 0",
               retired_count, watch_ready, busy);
    end
    vectors++;
    if (cycle_count !== 16'(m_cyc) || cycle_count !== 16'd10) begin
      miscompares++;
      $display("FAIL basic_cycles: got %0d want 10", cycle_count);
    end
  endtask

  task automatic test_same_reg();
    go();
    wb(0, 5'd10, 32'h1);
    wb(1, 5'd10, 32'h2);
    step();
    vectors++;
    if (watch_value[31:0] !== 32'h2 || watch_ready !== 2'b01 ||
        retired_count !== 16'd2) begin
      miscompares++;
      $display("FAIL same_reg: val %h rdy %b ret %0d want 2 01 2",
               watch_value[31:0], watch_ready, retired_count);
    end
    idle_in();
    fetch_complete = 1;
    repeat (DRAIN + 1) step();
    vectors++;
    if (done !== 1'b1 || m_ph != 3) begin
      miscompares++;
      $display("FAIL same_reg_done: got %b want 1", done);
    end
  endtask

  task automatic test_x0();
    go();
    wb(0, 5'd0, 32'hFFFF_FFFF);
    wb(1, 5'd12, 32'h1234);
    step();
    vectors++;
    if (watch_ready !== 2'b00 || watch_value !== 64'h0 ||
        retired_count !== 16'd1) begin
      miscompares++;
      $display("FAIL x0_unwatched: rdy %b val %h ret %0d want 00 0 1",
               watch_ready, watch_value, retired_count);
    end
    idle_in();
    fetch_complete = 1;
    repeat (DRAIN + 1) step();
    vectors++;
    if (done !== 1'b1 || retired_count !== 16'd1) begin
      miscompares++;
      $display("FAIL x0_done: done %b ret %0d want 1 1",
               done, retired_count);
    end
  endtask

  task automatic test_drain_glitch();
    go();
    fetch_complete = 1;
    step();
    repeat (5) step();
    pipe_busy = 1;
    step();
    pipe_busy = 0;
    fetch_complete = 0;
    repeat (DRAIN - 1) step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_early: done %b busy %b want 0 1", done, busy);
    end
    step();
    vectors++;
    if (done !== 1'b1 || m_ph != 3) begin
      miscompares++;
      $display("FAIL glitch_done: got %b want 1", done);
    end
  endtask

  task automatic test_timeout();
    int n;
    go();
    n = 0;
    while (!timed_out && n < 40) begin
      step();
      n++;
    end
    vectors++;
    if (timed_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || n !== TMO) begin
      miscompares++;
      $display("FAIL timeout_hit: tmo %b busy %b after %0d want 1 0 after %0d",
               timed_out, busy, n, TMO);
    end
    vectors++;
    if (cycle_count !== 16'(m_cyc)) begin
      miscompares++;
      $display("FAIL timeout_cycles: got %0d want %0d", cycle_count, m_cyc);
    end
    wb(0, 5'd10, 32'h77);
    step();
    vectors++;
    if (watch_ready !== 2'b00 || retired_count !== 16'd0 ||
        timed_out !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_ignore: rdy %b ret %0d tmo %b want 00 0 1",
               watch_ready, retired_count, timed_out);
    end
    idle_in();
  endtask

  task automatic test_async_reset();
    go();
    wb(0, 5'd11, 32'hCAFE);
    step();
    idle_in();
    fetch_complete = 1;
    step();
    repeat (3) step();
    #2;
    reset = 0;
    #1;
    vectors++;
    if ({watch_ready, watch_value, busy, done, timed_out,
         cycle_count, retired_count} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: rdy %b cyc %0d ret %0d busy %b want 0",
               watch_ready, cycle_count, retired_count, busy);
    end
    #2;
    reset = 1;
    model_reset();
    idle_in();
    step();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy %b done %b want 0 0", busy, done);
    end
    go();
    step();
    vectors++;
    if (cycle_count !== 16'd1 || busy !== 1'b1 || watch_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL fresh_run: cyc %0d busy %b rdy %b want 1 1 00",
               cycle_count, busy, watch_ready);
    end
  endtask

  task automatic test_random();
    logic [4:0] tbl [6];
    logic [4:0] a;
    tbl[0] = 5'd0;  tbl[1] = 5'd9;  tbl[2] = 5'd10;
    tbl[3] = 5'd11; tbl[4] = 5'd12; tbl[5] = 5'd13;
    for (int r = 0; r < 6; r++) begin
      go();
      for (int c = 0; c < 30; c++) begin
        idle_in();
        start = ($urandom_range(15) == 0);
        if (c < 6 || $urandom_range(3) == 0) begin
          for (int p = 0; p < NUM_WB; p++) begin
            if ($urandom_range(1) == 1) begin
              a = tbl[$urandom_range(5)];
              wb(p, a, $urandom);
            end
          end
        end
        fetch_complete = (c > 3) && ($urandom_range(2) != 0);
        pipe_busy = ($urandom_range(5) == 0);
        step();
        vectors++;
        if ({busy, done, timed_out} !==
            {m_ph == 1 || m_ph == 2, m_ph == 3, m_ph == 4}) begin
          miscompares++;
          $display("FAIL rand_flags r%0d c%0d: got %b model phase %0d",
                   r, c, {busy, done, timed_out}, m_ph);
        end
        vectors++;
        if (cycle_count !== 16'(m_cyc)) begin
          miscompares++;
          $display("FAIL rand_cycles r%0d c%0d: got %0d want %0d",
                   r, c, cycle_count, m_cyc);
        end
        vectors++;
        if (retired_count !== 16'(m_ret)) begin
          miscompares++;
          $display("FAIL rand_retired r%0d c%0d: got %0d want %0d",
                   r, c, retired_count, m_ret);
        end
        vectors++;
        if (watch_ready !== m_rdy) begin
          miscompares++;
          $display("FAIL rand_ready r%0d c%0d: got %b want %b",
                   r, c, watch_ready, m_rdy);
        end
        vectors++;
        if (watch_value !== {m_val[1], m_val[0]}) begin
          miscompares++;
          $display("FAIL rand_value r%0d c%0d: got %h want %h",
                   r, c, watch_value, {m_val[1], m_val[0]});
        end
      end
    end
    idle_in();
  endtask

  initial begin
    reset = 1;
    idle_in();
    model_reset();
    test_reset();
    test_basic();
    test_same_reg();
    test_x0();
    test_drain_glitch();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
